// File: rtl/neg_pkg.sv
// Shared definitions for the elastic negation pipeline: mode encodings and the
// width-generic negate/abs/saturate arithmetic used by stage 0.
package neg_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_NABS = 2'b11;

  // Arithmetic runs at this width; callers sign-extend and keep the low bits.
  localparam int CALC_W = 64;

  // Returns {ovf, z}. Only the most negative value of 'width' bits can overflow.
  function automatic logic [CALC_W:0] neg_calc(input logic signed [CALC_W-1:0] a,
                                               input logic [1:0] mode,
                                               input logic sat,
                                               input int width);
    logic signed [CALC_W-1:0] max_v;
    logic signed [CALC_W-1:0] min_v;
    logic signed [CALC_W-1:0] r;
    logic is_min;
    logic ovf;
    max_v  = (CALC_W'(64'sd1) <<< (width - 1)) - 64'sd1;
    min_v  = ~max_v;
    is_min = (a == min_v);
    r      = a;
    ovf    = 1'b0;
    case (mode)
      MODE_NEG: begin
        r   = -a;
        ovf = is_min;
      end
      MODE_ABS: begin
        r   = (a < 0) ? -a : a;
        ovf = is_min;
      end
      MODE_NABS: r = (a > 0) ? -a : a;
      default:   r = a;
    endcase
    if (ovf)
      r = sat ? max_v : min_v;
    return {ovf, r};
  endfunction

endpackage

// File: rtl/neg_stage.sv
// One elastic slot of the negation pipeline: holds a result and its overflow flag
// until the downstream slot (or consumer) takes it.
module neg_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             slot_ready,
  input  logic             next_ready,
  input  logic [WIDTH-1:0] in_z,
  input  logic             in_ovf,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_z,
  output logic             out_ovf
);

  logic load;

  assign load = in_valid & slot_ready;

  // Data is only written on load, so a stalled slot keeps its outputs stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_ovf   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_z     <= in_z;
      out_ovf   <= in_ovf;
    end else if (next_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/neg_pipe.sv
// Elastic two's-complement pass/negate/abs/-abs unit with configurable depth,
// optional saturation and a saturating count of delivered overflow results.
module neg_pipe
  import neg_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int STAGES   = 2,
  parameter bit SATURATE = 1'b1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             out_ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] ovf_count
);

  if (STAGES < 1 || STAGES > 4 || WIDTH < 2 || WIDTH > CALC_W) begin : g_bad_param
    $error("neg_pipe: STAGES must be 1..4 and WIDTH 2..%0d", CALC_W);
  end

  logic [CALC_W:0]   calc;
  logic [WIDTH-1:0]  calc_z;
  logic              calc_ovf;
  logic [STAGES-1:0] sv;
  logic [STAGES-1:0] sov;
  logic [WIDTH-1:0]  sz [STAGES];
  logic [STAGES:0]   rdy;
  logic              full_run;
  logic              xfer_ovf;

  assign calc     = neg_calc(CALC_W'($signed(in_a)), in_mode, SATURATE, WIDTH);
  assign calc_z   = calc[WIDTH-1:0];
  assign calc_ovf = calc[CALC_W];

  if (WIDTH < CALC_W) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^calc[CALC_W-1:WIDTH];
  end

  // Slot k can accept iff the consumer is draining or some slot from k onward is
  // empty; built from the valid bits directly so there is no ready-to-ready loop.
  always_comb begin
    rdy         = '0;
    rdy[STAGES] = out_ready;
    full_run    = 1'b1;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full_run = full_run & sv[k];
      rdy[k]   = out_ready | ~full_run;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_valid;
    logic [WIDTH-1:0] up_z;
    logic             up_ovf;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_z     = calc_z;
      assign up_ovf   = calc_ovf;
    end else begin : g_body
      assign up_valid = sv[k-1];
      assign up_z     = sz[k-1];
      assign up_ovf   = sov[k-1];
    end

    neg_stage #(.WIDTH(WIDTH)) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (up_valid),
      .slot_ready (rdy[k]),
      .next_ready (rdy[k+1]),
      .in_z       (up_z),
      .in_ovf     (up_ovf),
      .out_valid  (sv[k]),
      .out_z      (sz[k]),
      .out_ovf    (sov[k])
    );
  end

  assign in_ready  = rst_n & rdy[0];
  assign out_valid = sv[STAGES-1];
  assign out_z     = sz[STAGES-1];
  assign out_ovf   = sov[STAGES-1];
  assign xfer_ovf  = out_valid & out_ready & out_ovf;

  // A clear that coincides with an overflow delivery still records that delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf_count <= '0;
    else if (ovf_clr)
      ovf_count <= xfer_ovf ? CNT_W'(1) : '0;
    else if (xfer_ovf && ovf_count != '1)
      ovf_count <= ovf_count + 1'b1;
  end

endmodule

// File: tb/tb_neg_pipe.sv
// Scoreboard bench for neg_pipe: a saturating and a wrapping instance share stimulus;
// expected results come from an integer reference model, checked by a monitor.
module tb_neg_pipe;

  localparam logic [31:0] MINV = 32'h8000_0000;
  localparam logic [31:0] MAXV = 32'h7FFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_a;
  logic [1:0]  in_mode;
  logic        out_ready;
  logic        ovf_clr;
  logic        in_ready, out_valid, out_ovf;
  logic [31:0] out_z;
  logic [3:0]  ovf_count;
  logic        in_ready_w, out_valid_w, out_ovf_w;
  logic [31:0] out_z_w;
  logic [3:0]  ovf_count_w;

  typedef struct {
    logic [31:0] zs;
    logic [31:0] zw;
    bit          ovf;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   model_cnt = 0;
  bit   rnd_done = 0;

  neg_pipe #(.WIDTH(32), .STAGES(2), .SATURATE(1'b1), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_ovf(out_ovf), .ovf_clr(ovf_clr), .ovf_count(ovf_count)
  );

  neg_pipe #(.WIDTH(32), .STAGES(2), .SATURATE(1'b0), .CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .in_a(in_a), .in_mode(in_mode), .out_valid(out_valid_w), .out_ready(out_ready),
    .out_z(out_z_w), .out_ovf(out_ovf_w), .ovf_clr(ovf_clr), .ovf_count(ovf_count_w)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: exact integer result, then clamp/wrap if it does not fit in 32 bits.
  function automatic void model(input logic [31:0] a, input logic [1:0] mode, input bit sat,
                                output logic [31:0] z, output bit ovf);
    longint av, r;
    av = longint'($signed(a));
    case (mode)
      2'd0:    r = av;
      2'd1:    r = -av;
      2'd2:    r = (av < 0) ? -av : av;
      default: r = (av > 0) ? -av : av;
    endcase
    ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    if (ovf) z = sat ? MAXV : MINV;
    else     z = r[31:0];
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [1:0] mode, output int acc);
    exp_t e;
    bit   done = 0;
    bit   ovf_w;
    in_a     = a;
    in_mode  = mode;
    in_valid = 1'b1;
    acc      = -1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        model(a, mode, 1'b1, e.zs, e.ovf);
        model(a, mode, 1'b0, e.zw, ovf_w);
        q.push_back(e);
        acc  = cyc;
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: operand %h never accepted, required acceptance", a);
    end
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300 && q.size() > 0; i++) begin
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    checkOutput("drain_empty", q.size(), 0);
  endtask

  // Monitor: pops the scoreboard on every output transfer and tracks the counter.
  initial begin
    exp_t        e;
    bit          xo;
    bit          prev_stall = 0;
    logic [31:0] prev_z = '0;
    logic        prev_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q.delete();
        model_cnt  = 0;
        prev_stall = 0;
      end else begin
        checkOutput("ovf_count", ovf_count, model_cnt);
        checkOutput("ovf_count_wrap", ovf_count_w, model_cnt);
        checkOutput("valid_wrap", out_valid_w, out_valid);
        checkOutput("in_ready_wrap", in_ready_w, in_ready);
        if (prev_stall) begin
          checkOutput("stall_valid", out_valid, 1);
          checkOutput("stall_z", out_z, prev_z);
          checkOutput("stall_ovf", out_ovf, prev_ovf);
        end
        xo = 0;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_output: got z=%h, expected no output", out_z);
          end else begin
            e = q.pop_front();
            checkOutput("out_z", out_z, e.zs);
            checkOutput("out_ovf", out_ovf, e.ovf);
            checkOutput("out_z_wrap", out_z_w, e.zw);
            checkOutput("out_ovf_wrap", out_ovf_w, e.ovf);
            xo = e.ovf;
          end
        end
        if (ovf_clr)                    model_cnt = xo ? 1 : 0;
        else if (xo && model_cnt < 15)  model_cnt++;
        prev_stall = out_valid && !out_ready;
        prev_z     = out_z;
        prev_ovf   = out_ovf;
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int lat;
    in_valid  = 1'b0;
    in_a      = '0;
    in_mode   = 2'd0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    rst_n     = 1'b0;

    repeat (3) begin
      @(negedge clk);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_ovf_count", ovf_count, 0);
      checkOutput("rst_out_z", out_z, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Latency and simple values
    applyStimulus(32'd5, 2'd1, acc);
    lat = -1;
    for (int i = 0; i < 10 && lat < 0; i++) begin
      @(negedge clk);
      if (out_valid) lat = cyc - acc;
    end
    checkOutput("latency", lat, 2);
    @(posedge clk);
    #1;
    waitDrain();
    applyStimulus(32'd7, 2'd0, acc);
    waitDrain();

    // Most negative operand
    applyStimulus(MINV, 2'd2, acc);
    waitDrain();
    checkOutput("cnt_abs_min", ovf_count, 1);
    applyStimulus(MINV, 2'd3, acc);
    applyStimulus(32'd0, 2'd1, acc);
    waitDrain();

    // Backpressure window in cycles 3..7 of the stream
    fork
      begin
        for (int i = 1; i <= 10; i++) applyStimulus(i, 2'd1, acc);
      end
      begin
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        checkOutput("bp_in_ready_low", in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain();

    // Reset with two tokens in flight
    out_ready = 1'b0;
    applyStimulus(32'd100, 2'd1, acc);
    applyStimulus(32'd200, 2'd1, acc);
    checkOutput("pre_rst_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_in_ready", in_ready, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(32'd42, 2'd1, acc);
    waitDrain();

    // Counter saturation and clear
    for (int i = 0; i < 20; i++) applyStimulus(MINV, 2'd2, acc);
    waitDrain();
    checkOutput("cnt_saturated", ovf_count, 15);
    applyStimulus(MINV, 2'd2, acc);
    for (int i = 0; i < 10 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    checkOutput("cnt_clr_with_ovf", ovf_count, 1);
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    checkOutput("cnt_clr_alone", ovf_count, 0);

    // Randomized traffic with random backpressure and clears
    fork
      begin
        logic [31:0] a;
        for (int i = 0; i < 400; i++) begin
          case ($urandom_range(0, 7))
            0:       a = MINV;
            1:       a = MAXV;
            2:       a = 32'd0;
            3:       a = 32'd1;
            4:       a = 32'hFFFF_FFFF;
            default: a = $urandom;
          endcase
          applyStimulus(a, 2'($urandom_range(0, 3)), acc);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 9) < 7);
          ovf_clr   = ($urandom_range(0, 15) == 0);
        end
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
      end
    join
    waitDrain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
